imem_load_controller: RTL and testbench

- Sequences run-time program loading into the 16-word instruction memory through that memory's select/write/read side port.
- Holds the CPU while a program streams in, then optionally verifies the contents by readback checksum.
- On success it releases the CPU and pulses a restart so fetch begins at PC 0.
- Sits between the external load/debug interface and the instruction memory; the CPU core sees only cpu_hold and cpu_restart.

---
 rtl/imem_ctrl_pkg.sv | 14 +
 rtl/imem_xor_checksum.sv | 22 ++
 rtl/imem_load_controller.sv | 155 +++++++++++++++
 tb/tb_imem_load_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_ctrl_pkg.sv
// Shared constants for the instruction-memory load controller.
// State encodings are plain localparams so older tools can consume them.
package imem_ctrl_pkg;
  localparam int IMEM_DEPTH  = 16;
  localparam int IMEM_ADDR_W = 4;
  localparam int IMEM_DATA_W = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WRITE  = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_VERIFY = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_ERROR  = 3'd5;
endpackage

// File: rtl/imem_xor_checksum.sv
// Running XOR accumulator with synchronous clear; used for the write-side
// and readback-side checksums of a program load.
module imem_xor_checksum #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_sum
);
  logic [W-1:0] r_sum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_sum <= '0;
    else if (i_clear) r_sum <= '0;
    else if (i_en)    r_sum <= r_sum ^ i_data;
  end

  assign o_sum = r_sum;
endmodule

// File: rtl/imem_load_controller.sv
// Streams a program into the instruction memory while holding the CPU, then
// restarts it. Readback checksum verification is built when IMEM_LOAD_VERIFY_EN is defined.
module imem_load_controller
  import imem_ctrl_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_start,
  input  logic [ADDR_W:0]   i_load_len,
  input  logic              i_load_abort,
  input  logic              i_load_valid,
  input  logic [DATA_W-1:0] i_load_data,
  output logic              o_load_ready,
  output logic [ADDR_W-1:0] o_mem_select,
  output logic              o_mem_write,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_cpu_hold,
  output logic              o_cpu_restart,
  output logic              o_load_done,
  output logic              o_load_error,
  output logic [ADDR_W:0]   o_words_loaded
);
  localparam int CNT_W = ADDR_W + 1;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_words;
  logic [ADDR_W-1:0] r_sel;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;

  logic [CNT_W-1:0]  w_len_clamp;
  logic              w_start_ok;
  logic              w_accept;
  logic              w_abortable;
  logic              w_last_idx;

  assign w_len_clamp = (i_load_len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : i_load_len;
  assign w_start_ok  = i_load_start && (i_load_len != '0) &&
                       ((r_state == ST_IDLE) || (r_state == ST_ERROR));
  // Abort beats a same-cycle handshake, so the word is never written.
  assign w_accept    = (r_state == ST_WRITE) && i_load_valid && !i_load_abort;
  assign w_abortable = (r_state == ST_WRITE) || (r_state == ST_DRAIN) ||
                       (r_state == ST_VERIFY);
  assign w_last_idx  = (r_idx == r_len - CNT_W'(1));

`ifdef IMEM_LOAD_VERIFY_EN
  logic [DATA_W-1:0] w_wr_sum;
  logic [DATA_W-1:0] w_rb_sum;
  logic [DATA_W-1:0] w_rb_next;

  imem_xor_checksum #(.W(DATA_W)) u_wr_sum (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (w_start_ok),
    .i_en    (w_accept),
    .i_data  (i_load_data),
    .o_sum   (w_wr_sum)
  );

  imem_xor_checksum #(.W(DATA_W)) u_rb_sum (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (r_state == ST_DRAIN),
    .i_en    (r_state == ST_VERIFY),
    .i_data  (i_mem_rdata),
    .o_sum   (w_rb_sum)
  );

  // Include the word being read this cycle so the compare lands on the last VERIFY cycle.
  assign w_rb_next = w_rb_sum ^ i_mem_rdata;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^i_mem_rdata;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_words <= '0;
      r_sel   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_write <= 1'b0;
      case (r_state)
        ST_IDLE, ST_ERROR: begin
          if (w_start_ok) begin
            r_len   <= w_len_clamp;
            r_idx   <= '0;
            r_words <= '0;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (i_load_abort) begin
            r_state <= ST_ERROR;
          end else if (w_accept) begin
            r_sel   <= r_idx[ADDR_W-1:0];
            r_wdata <= i_load_data;
            r_write <= 1'b1;
            r_words <= r_words + CNT_W'(1);
            if (w_last_idx) r_state <= ST_DRAIN;
            else            r_idx   <= r_idx + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (i_load_abort) begin
            r_state <= ST_ERROR;
          end else begin
`ifdef IMEM_LOAD_VERIFY_EN
            r_idx   <= '0;
            r_sel   <= '0;
            r_state <= ST_VERIFY;
`else
            r_state <= ST_DONE;
`endif
          end
        end
`ifdef IMEM_LOAD_VERIFY_EN
        ST_VERIFY: begin
          if (i_load_abort) begin
            r_state <= ST_ERROR;
          end else if (w_last_idx) begin
            r_state <= (w_rb_next == w_wr_sum) ? ST_DONE : ST_ERROR;
          end else begin
            r_idx <= r_idx + CNT_W'(1);
            r_sel <= r_idx[ADDR_W-1:0] + ADDR_W'(1);
          end
        end
`endif
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_load_ready   = (r_state == ST_WRITE);
  assign o_mem_select   = r_sel;
  assign o_mem_write    = r_write;
  assign o_mem_wdata    = r_wdata;
  assign o_cpu_hold     = (r_state != ST_IDLE);
  assign o_cpu_restart  = (r_state == ST_DONE);
  assign o_load_done    = (r_state == ST_DONE);
  assign o_load_error   = (r_state == ST_ERROR);
  assign o_words_loaded = r_words;
endmodule

// File: tb/tb_imem_load_controller.sv
// Bench for imem_load_controller: a transaction-level model predicts every
// output each cycle; directed scenarios pin the model with literal values.
`timescale 1ns/1ps
module tb_imem_load_controller;
`ifdef IMEM_LOAD_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_start, i_abort, i_valid;
  logic [4:0]  i_len;
  logic [31:0] i_data;
  logic        o_ready, o_mem_write, o_cpu_hold, o_cpu_restart, o_load_done, o_load_error;
  logic [3:0]  o_mem_select;
  logic [31:0] o_mem_wdata, mem_rdata;
  logic [4:0]  o_words_loaded;
  logic        corrupt = 1'b0;

  always #5 clk = ~clk;

  imem_load_controller dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_load_start(i_start), .i_load_len(i_len), .i_load_abort(i_abort),
    .i_load_valid(i_valid), .i_load_data(i_data), .o_load_ready(o_ready),
    .o_mem_select(o_mem_select), .o_mem_write(o_mem_write), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(mem_rdata), .o_cpu_hold(o_cpu_hold), .o_cpu_restart(o_cpu_restart),
    .o_load_done(o_load_done), .o_load_error(o_load_error), .o_words_loaded(o_words_loaded)
  );

  // Instruction memory: registered write, combinational read, optional bit-0 fault at word 1.
  logic [31:0] bmem [16] = '{default: 32'h00000013};
  always @(posedge clk) if (o_mem_write) bmem[o_mem_select] <= o_mem_wdata;
  assign mem_rdata = bmem[o_mem_select] ^ {31'b0, corrupt && (o_mem_select == 4'd1)};

  // Model: m_active while words stream; m_tail counts cycles left until the done cycle.
  bit          m_active = 0, m_err = 0, m_wr = 0, m_fail = 0;
  int          m_len = 0, m_cnt = 0, m_tail = 0;
  logic [3:0]  m_wsel = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_img [16] = '{default: 32'h00000013};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 0; m_err <= 0; m_wr <= 0; m_fail <= 0;
      m_len <= 0; m_cnt <= 0; m_tail <= 0;
    end else begin
      if (m_wr) m_img[m_wsel] <= m_wdata;
      m_wr <= 0;
      if (i_abort && (m_active || m_tail > 1)) begin
        m_active <= 0; m_tail <= 0; m_err <= 1;
      end else if (m_active) begin
        if (i_valid) begin
          m_wr <= 1; m_wsel <= m_cnt[3:0]; m_wdata <= i_data; m_cnt <= m_cnt + 1;
          if (m_cnt + 1 == m_len) begin
            m_active <= 0;
            m_tail   <= VER ? m_len + 2 : 2;
            m_fail   <= VER && corrupt && (m_len > 1);
          end
        end
      end else if (m_tail > 0) begin
        if (m_tail == 2 && m_fail) begin m_tail <= 0; m_err <= 1; end
        else m_tail <= m_tail - 1;
      end else if (i_start && i_len != 0) begin
        m_len <= (i_len > 16) ? 16 : int'(i_len);
        m_cnt <= 0; m_err <= 0; m_active <= 1;
      end
    end
  end

  int n_chk = 0, n_pass = 0;
  int cyc_no = 0, tot_wr = 0, tot_done = 0, tot_rst = 0, last_done_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
    chk("load_ready",   32'(o_ready),        32'(m_active));
    chk("cpu_hold",     32'(o_cpu_hold),     32'(m_active || m_tail != 0 || m_err));
    chk("load_done",    32'(o_load_done),    32'(m_tail == 1));
    chk("cpu_restart",  32'(o_cpu_restart),  32'(m_tail == 1));
    chk("load_error",   32'(o_load_error),   32'(m_err));
    chk("mem_write",    32'(o_mem_write),    32'(m_wr));
    chk("words_loaded", 32'(o_words_loaded), 32'(m_cnt));
    if (m_wr) begin
      chk("mem_select", 32'(o_mem_select), 32'(m_wsel));
      chk("mem_wdata",  o_mem_wdata,       m_wdata);
    end
    if (o_mem_write)   tot_wr++;
    if (o_load_done) begin tot_done++; last_done_cyc = cyc_no; end
    if (o_cpu_restart) tot_rst++;
    @(posedge clk);
    cyc_no++;
    #1;
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_ready"},   32'(o_ready), 0);
    chk({tag, "_mwrite"},  32'(o_mem_write), 0);
    chk({tag, "_msel"},    32'(o_mem_select), 0);
    chk({tag, "_mwdata"},  o_mem_wdata, 0);
    chk({tag, "_hold"},    32'(o_cpu_hold), 0);
    chk({tag, "_restart"}, 32'(o_cpu_restart), 0);
    chk({tag, "_done"},    32'(o_load_done), 0);
    chk({tag, "_error"},   32'(o_load_error), 0);
    chk({tag, "_words"},   32'(o_words_loaded), 0);
  endtask

  task automatic img_check();
    for (int i = 0; i < 16; i++) chk("mem_image", bmem[i], m_img[i]);
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random valid plus stray starts.
  task automatic run_load(input int ln, input int mode, input int abort_at,
                          input bit rnd, input logic [31:0] base, output int acc_cyc);
    int n, c;
    n = 0; c = 0; acc_cyc = -1;
    i_start = 1'b1; i_len = 5'(ln);
    tick();
    i_start = 1'b0; i_len = 5'($urandom);
    while (o_ready && c < 200) begin
      i_valid = (mode == 0) || (mode == 1 && c % 2 == 0) ||
                (mode == 2 && $urandom_range(0, 2) != 0);
      i_data  = rnd ? $urandom : base + 32'(n);
      i_abort = i_valid && (n == abort_at);
      if (mode == 2 && $urandom_range(0, 7) == 0) begin i_start = 1'b1; i_len = 5'($urandom); end
      tick();
      if (i_valid && !i_abort) begin n++; acc_cyc = cyc_no - 1; end
      i_valid = 1'b0; i_abort = 1'b0; i_start = 1'b0;
      c++;
    end
    chk("stream_bound", 32'(o_ready), 0);
  endtask

  task automatic settle();
    int c;
    c = 0;
    while (o_cpu_hold && !o_load_error && c < 80) begin tick(); c++; end
    chk("settle_bound", 32'(o_cpu_hold && !o_load_error), 0);
  endtask

  initial begin
    int acc, w0, d0, r0, ln, ab;
    i_start = 0; i_abort = 0; i_valid = 0; i_len = 0; i_data = 0;
    #2 rst_n = 1'b0;
    #1 rst_check("por");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Full 16-word load, no stalls.
    w0 = tot_wr; d0 = tot_done; r0 = tot_rst;
    run_load(16, 0, -1, 1'b0, 32'h00100093, acc);
    settle();
    chk("full_writes",  32'(tot_wr - w0), 16);
    chk("full_done",    32'(tot_done - d0), 1);
    chk("full_restart", 32'(tot_rst - r0), 1);
    chk("full_latency", 32'(last_done_cyc - acc), VER ? 32'd18 : 32'd2);
    chk("full_words",   32'(o_words_loaded), 16);
    chk("full_hold",    32'(o_cpu_hold), 0);
    chk("full_word15",  bmem[15], 32'h001000A2);
    img_check();

    // Three words with valid toggling.
    w0 = tot_wr; d0 = tot_done;
    run_load(3, 1, -1, 1'b0, 32'hA5A50000, acc);
    settle();
    chk("stall_writes", 32'(tot_wr - w0), 3);
    chk("stall_done",   32'(tot_done - d0), 1);
    chk("stall_words",  32'(o_words_loaded), 3);
    chk("stall_word2",  bmem[2], 32'hA5A50002);
    img_check();

    // Corrupted readback at word 1, then a clean reload.
    corrupt = 1'b1;
    d0 = tot_done;
    run_load(4, 0, -1, 1'b1, 32'h0, acc);
    settle();
    repeat (3) tick();
    chk("corrupt_error", 32'(o_load_error), VER ? 32'd1 : 32'd0);
    chk("corrupt_done",  32'(tot_done - d0), VER ? 32'd0 : 32'd1);
    chk("corrupt_hold",  32'(o_cpu_hold), VER ? 32'd1 : 32'd0);
    corrupt = 1'b0;
    d0 = tot_done;
    run_load(4, 0, -1, 1'b1, 32'h0, acc);
    settle();
    chk("reload_error", 32'(o_load_error), 0);
    chk("reload_done",  32'(tot_done - d0), 1);
    img_check();

    // Length 0 is ignored; length 20 clamps to 16.
    i_start = 1'b1; i_len = 5'd0;
    tick();
    i_start = 1'b0;
    tick();
    chk("len0_hold",  32'(o_cpu_hold), 0);
    chk("len0_ready", 32'(o_ready), 0);
    w0 = tot_wr;
    run_load(20, 0, -1, 1'b1, 32'h0, acc);
    settle();
    chk("len20_writes", 32'(tot_wr - w0), 16);
    chk("len20_words",  32'(o_words_loaded), 16);

    // Abort coincident with the handshake of word 5 of 8.
    w0 = tot_wr; d0 = tot_done;
    run_load(8, 0, 5, 1'b0, 32'h0BAD0000, acc);
    settle();
    chk("abort_writes", 32'(tot_wr - w0), 5);
    chk("abort_error",  32'(o_load_error), 1);
    chk("abort_words",  32'(o_words_loaded), 5);
    chk("abort_done",   32'(tot_done - d0), 0);
    img_check();

    // Reset while streaming, after word 2 is accepted.
    i_start = 1'b1; i_len = 5'd8;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_data = 32'hCAFE0000 + 32'(k);
      tick();
    end
    i_valid = 1'b0;
    rst_n = 1'b0;
    #1 rst_check("midrst");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    img_check();

    // Randomized loads with random stalls, aborts, stray starts and late aborts.
    for (int it = 0; it < 30; it++) begin
      ln = $urandom_range(0, 20);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : -1;
      corrupt = ($urandom_range(0, 3) == 0);
      run_load(ln, 2, ab, 1'b1, 32'h0, acc);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, ln + 2)) tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
      end
      settle();
      tick();
      img_check();
    end
    corrupt = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
